// File: rtl/diff_pkg.sv
// Shared types and helpers for the difftest commit compactor: the buffered
// commit record layout and a constant-foldable ceil(log2) for pointer sizing.
package diff_pkg;

    localparam int GPR_IDX_W  = 8;
    localparam int INSTR_W    = 32;
    localparam int REC_PC_W   = 64;
    localparam int REC_DATA_W = 64;

    typedef struct packed {
        logic [REC_PC_W-1:0]   pc;
        logic [INSTR_W-1:0]    instr;
        logic                  wen;
        logic [GPR_IDX_W-1:0]  wdest;
        logic [REC_DATA_W-1:0] wdata;
        logic                  skip;
    } commit_rec_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/diff_commit_compactor_if.sv
// Retire-side and difftest-side buses of the commit compactor, bundled so the
// producer (master) and the compactor (slave) see mirrored directions.
interface diff_commit_compactor_if
    import diff_pkg::*;
#(
    parameter int COMMIT_WIDTH = 4,
    parameter int OUT_WIDTH    = 2,
    parameter int PC_W         = 64,
    parameter int DATA_W       = 64
);

    logic [COMMIT_WIDTH-1:0]           in_valid;
    logic [COMMIT_WIDTH*PC_W-1:0]      in_pc;
    logic [COMMIT_WIDTH*INSTR_W-1:0]   in_instr;
    logic [COMMIT_WIDTH-1:0]           in_wen;
    logic [COMMIT_WIDTH*GPR_IDX_W-1:0] in_wdest;
    logic [COMMIT_WIDTH*DATA_W-1:0]    in_wdata;
    logic [COMMIT_WIDTH-1:0]           in_skip;
    logic                              in_ready;

    logic [OUT_WIDTH-1:0]              out_valid;
    logic [OUT_WIDTH*PC_W-1:0]         out_pc;
    logic [OUT_WIDTH*INSTR_W-1:0]      out_instr;
    logic [OUT_WIDTH-1:0]              out_wen;
    logic [OUT_WIDTH*GPR_IDX_W-1:0]    out_wdest;
    logic [OUT_WIDTH*DATA_W-1:0]       out_wdata;
    logic [OUT_WIDTH-1:0]              out_skip;
    logic [OUT_WIDTH*8-1:0]            out_index;
    logic [63:0]                       commit_count;
    logic                              overflow_err;

    modport master (
        output in_valid, in_pc, in_instr, in_wen, in_wdest, in_wdata, in_skip,
        input  in_ready,
        input  out_valid, out_pc, out_instr, out_wen, out_wdest, out_wdata,
               out_skip, out_index, commit_count, overflow_err
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_wen, in_wdest, in_wdata, in_skip,
        output in_ready,
        output out_valid, out_pc, out_instr, out_wen, out_wdest, out_wdata,
               out_skip, out_index, commit_count, overflow_err
    );

endinterface

// File: rtl/diff_compact_sel.sv
// Prefix popcount over the retire valid vector: each slot's write offset is the
// number of valid slots below it, so valid slots pack densely in slot order.
module diff_compact_sel
    import diff_pkg::*;
#(
    parameter  int CW    = 4,
    localparam int OFF_W = (CW > 1) ? clog2(CW) : 1,
    localparam int NI_W  = clog2(CW + 1)
) (
    input  logic [CW-1:0]            valid,
    output logic [CW-1:0][OFF_W-1:0] offset,
    output logic [NI_W-1:0]          n_in
);

    logic [NI_W-1:0] acc_s;

    // Running count of valid slots seen so far gives each slot its offset.
    always_comb begin
        acc_s  = '0;
        offset = '0;
        for (int k = 0; k < CW; k++) begin
            offset[k] = OFF_W'(acc_s);
            acc_s     = acc_s + NI_W'(valid[k]);
        end
        n_in = acc_s;
    end

endmodule

// File: rtl/diff_commit_compactor.sv
// Compacts sparse ROB retire slots into a circular buffer in retire order and
// drains up to OUT_WIDTH contiguous records per cycle to the difftest ports.
module diff_commit_compactor
    import diff_pkg::*;
#(
    parameter int COMMIT_WIDTH = 4,
    parameter int OUT_WIDTH    = 2,
    parameter int DEPTH        = 16,
    parameter int PC_W         = 64,
    parameter int DATA_W       = 64
) (
    input logic                    clock,
    input logic                    reset,
    diff_commit_compactor_if.slave bus
);

    localparam int IDX_W = clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int OFF_W = (COMMIT_WIDTH > 1) ? clog2(COMMIT_WIDTH) : 1;
    localparam int NI_W  = clog2(COMMIT_WIDTH + 1);

    logic [PTR_W-1:0]                    head_r;
    logic [PTR_W-1:0]                    tail_r;
    logic [PTR_W-1:0]                    count_s;
    logic [PTR_W-1:0]                    n_out_s;
    logic                                in_ready_s;
    logic [COMMIT_WIDTH-1:0][OFF_W-1:0]  offset_s;
    logic [NI_W-1:0]                     n_in_s;
    logic [COMMIT_WIDTH-1:0][IDX_W-1:0]  wr_idx_s;
    commit_rec_t [COMMIT_WIDTH-1:0]      in_rec_s;
    logic [OUT_WIDTH-1:0][IDX_W-1:0]     rd_idx_s;
    logic [OUT_WIDTH-1:0]                take_s;
    logic [OUT_WIDTH*8-1:0]              index_s;

    commit_rec_t                         buf_r [DEPTH];

    logic [OUT_WIDTH-1:0]                out_valid_r;
    logic [OUT_WIDTH*PC_W-1:0]           out_pc_r;
    logic [OUT_WIDTH*INSTR_W-1:0]        out_instr_r;
    logic [OUT_WIDTH-1:0]                out_wen_r;
    logic [OUT_WIDTH*GPR_IDX_W-1:0]      out_wdest_r;
    logic [OUT_WIDTH*DATA_W-1:0]         out_wdata_r;
    logic [OUT_WIDTH-1:0]                out_skip_r;
    logic [63:0]                         commit_count_r;
    logic                                overflow_r;

    diff_compact_sel #(.CW(COMMIT_WIDTH)) u_sel (
        .valid  (bus.in_valid),
        .offset (offset_s),
        .n_in   (n_in_s)
    );

    // Occupancy, admission and drain amount, all from registered pointers.
    always_comb begin
        count_s    = tail_r - head_r;
        in_ready_s = (count_s <= PTR_W'(DEPTH - COMMIT_WIDTH));
        if (count_s < PTR_W'(OUT_WIDTH)) begin
            n_out_s = count_s;
        end else begin
            n_out_s = PTR_W'(OUT_WIDTH);
        end
        for (int j = 0; j < OUT_WIDTH; j++) begin
            rd_idx_s[j] = head_r[IDX_W-1:0] + IDX_W'(j);
            take_s[j]   = (PTR_W'(j) < n_out_s);
            index_s[j*8 +: 8] = 8'(j);
        end
    end

    // Unpack retire slots into records and their compacted buffer addresses.
    always_comb begin
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            in_rec_s[k]                 = '0;
            in_rec_s[k].pc[PC_W-1:0]    = bus.in_pc[k*PC_W +: PC_W];
            in_rec_s[k].instr           = bus.in_instr[k*INSTR_W +: INSTR_W];
            in_rec_s[k].wen             = bus.in_wen[k];
            in_rec_s[k].wdest           = bus.in_wdest[k*GPR_IDX_W +: GPR_IDX_W];
            in_rec_s[k].wdata[DATA_W-1:0] = bus.in_wdata[k*DATA_W +: DATA_W];
            in_rec_s[k].skip            = bus.in_skip[k];
            wr_idx_s[k] = tail_r[IDX_W-1:0] + IDX_W'(offset_s[k]);
        end
    end

    // Pointers, commit counter and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r         <= '0;
            tail_r         <= '0;
            commit_count_r <= 64'd0;
            overflow_r     <= 1'b0;
        end else begin
            head_r         <= head_r + n_out_s;
            commit_count_r <= commit_count_r + 64'(n_out_s);
            if (in_ready_s) begin
                tail_r <= tail_r + PTR_W'(n_in_s);
            end else begin
                tail_r <= tail_r;
            end
            // A group arriving while not ready is dropped whole, never split.
            if (!in_ready_s && (n_in_s != '0)) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Record storage; contents past head are don't-care, so no reset needed.
    always_ff @(posedge clock) begin
        if (!reset && in_ready_s) begin
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (bus.in_valid[k]) begin
                    buf_r[wr_idx_s[k]] <= in_rec_s[k];
                end
            end
        end
    end

    // Difftest output registers; slots beyond n_out are forced to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_r <= '0;
            out_pc_r    <= '0;
            out_instr_r <= '0;
            out_wen_r   <= '0;
            out_wdest_r <= '0;
            out_wdata_r <= '0;
            out_skip_r  <= '0;
        end else begin
            out_valid_r <= take_s;
            for (int j = 0; j < OUT_WIDTH; j++) begin
                if (take_s[j]) begin
                    out_pc_r[j*PC_W +: PC_W]             <= buf_r[rd_idx_s[j]].pc[PC_W-1:0];
                    out_instr_r[j*INSTR_W +: INSTR_W]    <= buf_r[rd_idx_s[j]].instr;
                    out_wen_r[j]                         <= buf_r[rd_idx_s[j]].wen;
                    out_wdest_r[j*GPR_IDX_W +: GPR_IDX_W] <= buf_r[rd_idx_s[j]].wdest;
                    out_wdata_r[j*DATA_W +: DATA_W]      <= buf_r[rd_idx_s[j]].wdata[DATA_W-1:0];
                    out_skip_r[j]                        <= buf_r[rd_idx_s[j]].skip;
                end else begin
                    out_pc_r[j*PC_W +: PC_W]             <= '0;
                    out_instr_r[j*INSTR_W +: INSTR_W]    <= '0;
                    out_wen_r[j]                         <= 1'b0;
                    out_wdest_r[j*GPR_IDX_W +: GPR_IDX_W] <= '0;
                    out_wdata_r[j*DATA_W +: DATA_W]      <= '0;
                    out_skip_r[j]                        <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_pc       = out_pc_r;
    assign bus.out_instr    = out_instr_r;
    assign bus.out_wen      = out_wen_r;
    assign bus.out_wdest    = out_wdest_r;
    assign bus.out_wdata    = out_wdata_r;
    assign bus.out_skip     = out_skip_r;
    assign bus.out_index    = index_s;
    assign bus.commit_count = commit_count_r;
    assign bus.overflow_err = overflow_r;

endmodule
